// File: rtl/ball_pkg.sv
// ============================================================================
// Module   : ball_pkg
// Purpose  : Shared types and helpers for the ball motion controller.
//            - ball_state_t : controller state (IDLE, RUN, LOST)
//            - wide_t       : wide signed working type for saturating math
//            - sat_add      : a + b, clamped into [lo, hi]
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ball_pkg;

    // Wide enough that sign-extended positions/speeds plus one addend can
    // never overflow before the clamp is applied.
    localparam int WIDE_W = 40;

    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } ball_state_t;

    function automatic wide_t sat_add(input wide_t a, input wide_t b,
                                      input wide_t lo, input wide_t hi);
        wide_t sum;
        sum = a + b;
        if (sum < lo) begin
            sat_add = lo;
        end else if (sum > hi) begin
            sat_add = hi;
        end else begin
            sat_add = sum;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/ball_motion_controller_axis.sv
// ============================================================================
// Module   : axis_integrator
// Purpose  : One axis of ball motion: fixed-point position accumulator,
//            signed speed register, edge reflection, flipper boost and
//            gravity, all with magnitude clamping.
// Ports    : clk, resetN        - clock, synchronous active-high reset
//            i_hold             - freeze every register
//            i_do_init          - reload initial position, clear speed
//            i_do_launch        - load launch speed
//            i_do_run           - axis is in flight
//            i_frame            - frame tick (advance position, gravity)
//            i_boost_hit        - flipper contact (reflect + boost if speed>0)
//            i_pos_hit          - edge blocking positive motion
//            i_neg_hit          - edge blocking negative motion
//            o_pos_int          - integer pixel position (floor)
//            o_beyond_limit     - next integer position >= LIMIT_POS
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_integrator
    import ball_pkg::*;
#(
    parameter int POS_W        = 11,
    parameter int FRAC_BITS    = 6,
    parameter int SPEED_W      = 16,
    parameter int INIT_POS     = 0,
    parameter int LAUNCH_SPEED = 0,
    parameter int GRAVITY      = 0,
    parameter int MAX_SPEED    = 230,
    parameter int BOOST        = 0,
    parameter int LIMIT_POS    = 0
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    i_hold,
    input  logic                    i_do_init,
    input  logic                    i_do_launch,
    input  logic                    i_do_run,
    input  logic                    i_frame,
    input  logic                    i_boost_hit,
    input  logic                    i_pos_hit,
    input  logic                    i_neg_hit,
    output logic signed [POS_W-1:0] o_pos_int,
    output logic                    o_beyond_limit
);

    localparam int PW = POS_W + FRAC_BITS + 1;

    localparam wide_t c_pos_max = (wide_t'(1) <<< (PW - 1)) - wide_t'(1);
    localparam wide_t c_pos_min = -(wide_t'(1) <<< (PW - 1));
    localparam wide_t c_spd_max = wide_t'(MAX_SPEED);
    localparam wide_t c_spd_min = -wide_t'(MAX_SPEED);
    localparam logic signed [PW-1:0] c_init_pos = PW'(wide_t'(INIT_POS) <<< FRAC_BITS);

    logic signed [PW-1:0]      r_pos;
    logic signed [SPEED_W-1:0] r_speed;

    logic signed [PW-1:0]      w_pos_next;
    logic signed [POS_W:0]     w_next_int;
    logic signed [SPEED_W-1:0] w_spd_reflect;
    logic signed [SPEED_W-1:0] w_spd_gravity;
    logic signed [SPEED_W-1:0] w_spd_launch;
    logic                      w_spd_neg;
    logic                      w_spd_pos;
    logic                      w_reflect;

    assign w_spd_neg = r_speed[SPEED_W-1];
    assign w_spd_pos = !w_spd_neg && (r_speed != '0);

    assign w_pos_next    = PW'(sat_add(wide_t'(r_pos), wide_t'(r_speed), c_pos_min, c_pos_max));
    assign w_spd_gravity = SPEED_W'(sat_add(wide_t'(r_speed), wide_t'(GRAVITY), c_spd_min, c_spd_max));
    assign w_spd_launch  = SPEED_W'(sat_add(wide_t'(LAUNCH_SPEED), wide_t'(0), c_spd_min, c_spd_max));

    // Each reflection only fires while the speed still points into the edge,
    // so a persisting overlap cannot flip the ball back and forth.
    always_comb begin
        w_reflect     = 1'b0;
        w_spd_reflect = r_speed;
        if (i_boost_hit && w_spd_pos) begin
            w_reflect     = 1'b1;
            w_spd_reflect = SPEED_W'(sat_add(-wide_t'(r_speed), -wide_t'(BOOST), c_spd_min, c_spd_max));
        end else if ((i_pos_hit && w_spd_pos) || (i_neg_hit && w_spd_neg)) begin
            w_reflect     = 1'b1;
            w_spd_reflect = SPEED_W'(sat_add(-wide_t'(r_speed), wide_t'(0), c_spd_min, c_spd_max));
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_pos   <= c_init_pos;
            r_speed <= '0;
        end else if (!i_hold) begin
            if (i_do_init) begin
                r_pos   <= c_init_pos;
                r_speed <= '0;
            end else if (i_do_launch) begin
                r_speed <= w_spd_launch;
            end else if (i_do_run) begin
                // A collision owns the speed update; gravity only when none.
                if (w_reflect) begin
                    r_speed <= w_spd_reflect;
                end else if (i_frame) begin
                    r_speed <= w_spd_gravity;
                end
                if (i_frame) begin
                    r_pos <= w_pos_next;
                end
            end
        end
    end

    // Slicing off the fraction is an arithmetic shift, i.e. floor toward -inf.
    assign o_pos_int      = r_pos[FRAC_BITS +: POS_W];
    assign w_next_int     = $signed(w_pos_next[PW-1:FRAC_BITS]);
    assign o_beyond_limit = (wide_t'(w_next_int) >= wide_t'(LIMIT_POS));

endmodule

`default_nettype wire

// File: rtl/ball_motion_controller.sv
// ============================================================================
// Module   : ball_motion_controller
// Purpose  : Single-ball motion controller: IDLE/RUN/LOST sequencing, per
//            frame integration with gravity, border/flipper reflection and
//            ball-lost detection with automatic re-arm.
// Ports    : clk, resetN (sync, active-high)
//            startOfFrame, collisionBorders, collisionFlipper, HitEdgeCode
//            ([3] left, [2] top, [1] right, [0] bottom), launch, pause
//            topLeftX / topLeftY (signed pixels), running, ballLost (pulse)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_motion_controller
    import ball_pkg::*;
#(
    parameter int POS_W          = 11,
    parameter int FRAC_BITS      = 6,
    parameter int SPEED_W        = 16,
    parameter int INITIAL_X      = 280,
    parameter int INITIAL_Y      = 185,
    parameter int LAUNCH_X_SPEED = 0,
    parameter int LAUNCH_Y_SPEED = 100,
    parameter int GRAVITY        = 4,
    parameter int MAX_SPEED      = 230,
    parameter int FLIPPER_BOOST  = 16,
    parameter int LOST_Y         = 470
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    collisionBorders,
    input  logic                    collisionFlipper,
    input  logic [3:0]              HitEdgeCode,
    input  logic                    launch,
    input  logic                    pause,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic                    running,
    output logic                    ballLost
);

    // The integer X position can never reach 2^POS_W, so the X axis never
    // reports a loss.
    localparam int c_x_unreachable = 1 << POS_W;

    ball_state_t r_state;

    logic w_do_launch;
    logic w_do_run;
    logic w_do_init;
    logic w_x_beyond;
    logic w_y_beyond;
    logic w_lost_hit;

    assign w_do_launch = (r_state == IDLE) && launch;
    assign w_do_run    = (r_state == RUN);
    assign w_do_init   = (r_state == LOST);
    assign w_lost_hit  = startOfFrame && (w_y_beyond || w_x_beyond);

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_state  <= IDLE;
            running  <= 1'b0;
            ballLost <= 1'b0;
        end else if (!pause) begin
            case (r_state)
                IDLE: begin
                    if (launch) begin
                        r_state <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_lost_hit) begin
                        r_state  <= LOST;
                        running  <= 1'b0;
                        ballLost <= 1'b1;
                    end
                end
                LOST: begin
                    r_state  <= IDLE;
                    ballLost <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    running  <= 1'b0;
                    ballLost <= 1'b0;
                end
            endcase
        end
    end

    axis_integrator #(
        .POS_W       (POS_W),
        .FRAC_BITS   (FRAC_BITS),
        .SPEED_W     (SPEED_W),
        .INIT_POS    (INITIAL_X),
        .LAUNCH_SPEED(LAUNCH_X_SPEED),
        .GRAVITY     (0),
        .MAX_SPEED   (MAX_SPEED),
        .BOOST       (0),
        .LIMIT_POS   (c_x_unreachable)
    ) u_axis_x (
        .clk           (clk),
        .resetN        (resetN),
        .i_hold        (pause),
        .i_do_init     (w_do_init),
        .i_do_launch   (w_do_launch),
        .i_do_run      (w_do_run),
        .i_frame       (startOfFrame),
        .i_boost_hit   (1'b0),
        .i_pos_hit     (collisionBorders && HitEdgeCode[1]),
        .i_neg_hit     (collisionBorders && HitEdgeCode[3]),
        .o_pos_int     (topLeftX),
        .o_beyond_limit(w_x_beyond)
    );

    axis_integrator #(
        .POS_W       (POS_W),
        .FRAC_BITS   (FRAC_BITS),
        .SPEED_W     (SPEED_W),
        .INIT_POS    (INITIAL_Y),
        .LAUNCH_SPEED(LAUNCH_Y_SPEED),
        .GRAVITY     (GRAVITY),
        .MAX_SPEED   (MAX_SPEED),
        .BOOST       (FLIPPER_BOOST),
        .LIMIT_POS   (LOST_Y)
    ) u_axis_y (
        .clk           (clk),
        .resetN        (resetN),
        .i_hold        (pause),
        .i_do_init     (w_do_init),
        .i_do_launch   (w_do_launch),
        .i_do_run      (w_do_run),
        .i_frame       (startOfFrame),
        .i_boost_hit   (collisionFlipper),
        .i_pos_hit     (collisionBorders && HitEdgeCode[0]),
        .i_neg_hit     (collisionBorders && HitEdgeCode[2]),
        .o_pos_int     (topLeftY),
        .o_beyond_limit(w_y_beyond)
    );

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_controller.sv
// ============================================================================
// Module   : tb_ball_motion_controller
// Purpose  : Self-checking bench for ball_motion_controller. A pixel/speed
//            model tracks the ball from the behavioural rules; outputs are
//            compared every cycle, plus hand-computed literal checkpoints.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ball_motion_controller;

    localparam int POS_W = 11;
    localparam int IX    = 280;
    localparam int IY    = 185;
    localparam int LX    = 40;   // non-zero so the X reflection paths move
    localparam int LY    = 100;
    localparam int GRAV  = 4;
    localparam int MAXS  = 230;
    localparam int BOOST = 16;
    localparam int LOSTY = 470;
    localparam int SCALE = 64;
    localparam int PMAX  = (1 << 17) - 1;
    localparam int PMIN  = -(1 << 17);

    localparam int M_IDLE = 0;
    localparam int M_FLY  = 1;
    localparam int M_GONE = 2;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    logic sof = 1'b0, border = 1'b0, flipper = 1'b0, launch = 1'b0, pause = 1'b0;
    logic [3:0] hit = 4'h0;
    logic signed [POS_W-1:0] topLeftX, topLeftY;
    logic running, ballLost;

    always #5 clk = ~clk;

    ball_motion_controller #(
        .POS_W(POS_W), .FRAC_BITS(6), .SPEED_W(16),
        .INITIAL_X(IX), .INITIAL_Y(IY),
        .LAUNCH_X_SPEED(LX), .LAUNCH_Y_SPEED(LY),
        .GRAVITY(GRAV), .MAX_SPEED(MAXS), .FLIPPER_BOOST(BOOST), .LOST_Y(LOSTY)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof),
        .collisionBorders(border), .collisionFlipper(flipper),
        .HitEdgeCode(hit), .launch(launch), .pause(pause),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .running(running), .ballLost(ballLost)
    );

    // ---------------- model ----------------
    int m_mode, m_px, m_py, m_vx, m_vy;
    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    function automatic int clampv(input int v);
        return (v > MAXS) ? MAXS : ((v < -MAXS) ? -MAXS : v);
    endfunction

    function automatic int satp(input int v);
        return (v > PMAX) ? PMAX : ((v < PMIN) ? PMIN : v);
    endfunction

    function automatic int fdiv(input int p);
        return (p >= 0) ? (p / SCALE) : -((-p + SCALE - 1) / SCALE);
    endfunction

    always @(posedge clk) begin : model
        int  nvx, nvy;
        bit  ycol;
        if (resetN) begin
            m_mode = M_IDLE; m_px = IX * SCALE; m_py = IY * SCALE; m_vx = 0; m_vy = 0;
        end else if (!pause) begin
            if (m_mode == M_IDLE) begin
                if (launch) begin
                    m_vx = clampv(LX); m_vy = clampv(LY); m_mode = M_FLY;
                end
            end else if (m_mode == M_FLY) begin
                nvx = m_vx;
                if (border && ((hit[3] && m_vx < 0) || (hit[1] && m_vx > 0))) nvx = -m_vx;
                nvy  = m_vy;
                ycol = 1'b0;
                if (flipper && m_vy > 0) begin
                    nvy = clampv(-(m_vy + BOOST)); ycol = 1'b1;
                end else if (border && hit[0] && m_vy > 0) begin
                    nvy = -m_vy; ycol = 1'b1;
                end else if (border && hit[2] && m_vy < 0) begin
                    nvy = -m_vy; ycol = 1'b1;
                end
                if (sof) begin
                    m_px = satp(m_px + m_vx);
                    m_py = satp(m_py + m_vy);
                    if (!ycol) nvy = clampv(m_vy + GRAV);
                    if (fdiv(m_py) >= LOSTY) m_mode = M_GONE;
                end
                m_vx = clampv(nvx);
                m_vy = clampv(nvy);
            end else begin
                m_mode = M_IDLE; m_px = IX * SCALE; m_py = IY * SCALE; m_vx = 0; m_vy = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_topLeftX", int'(topLeftX), fdiv(m_px));
            chk("model_topLeftY", int'(topLeftY), fdiv(m_py));
            chk("model_running",  int'(running),  (m_mode == M_FLY)  ? 1 : 0);
            chk("model_ballLost", int'(ballLost), (m_mode == M_GONE) ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit s, input bit b, input bit f, input logic [3:0] h,
                         input bit l, input bit p);
        sof = s; border = b; flipper = f; hit = h; launch = l; pause = p;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic frame(input bit p);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, p);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, p);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, p);
    endtask

    // {sof, border, flipper, hit[3:0]}
    logic [6:0] vec [9] = '{
        7'b0_1_0_1000, 7'b0_1_0_1000, 7'b1_0_1_0000, 7'b0_0_1_0000, 7'b1_1_0_0100,
        7'b1_1_0_1010, 7'b0_0_0_0000, 7'b1_1_1_0001, 7'b1_0_0_0000
    };

    initial begin
        bit found;
        @(negedge clk);
        @(negedge clk);
        check_en = 1'b1;
        chk("reset_running", int'(running), 0);
        chk("reset_ballLost", int'(ballLost), 0);
        chk("reset_X", int'(topLeftX), 280);
        chk("reset_Y", int'(topLeftY), 185);
        resetN = 1'b0;
        idle();

        // launch then two frames: Y speed 100 -> 104 -> 108
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("launch_running", int'(running), 1);
        frame(1'b0);
        frame(1'b0);
        chk("two_frames_Y", int'(topLeftY), 188);
        chk("two_frames_X", int'(topLeftX), 281);

        // pause across five frame pulses, then resume
        for (int i = 0; i < 5; i++) frame(1'b1);
        chk("paused_Y", int'(topLeftY), 188);
        chk("paused_running", int'(running), 1);
        frame(1'b0);
        chk("resume_Y", int'(topLeftY), 189);
        frame(1'b0);
        frame(1'b0);

        // bottom border held 3 cycles with Yspeed = 120, first cycle is a frame
        drive(1'b1, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
        chk("bottom_hit_Y", int'(topLeftY), 195);
        frame(1'b0);
        chk("bottom_after_Y", int'(topLeftY), 193);

        // right + top edges together
        drive(1'b0, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0);
        frame(1'b0);
        chk("right_top_X", int'(topLeftX), 283);
        chk("right_top_Y", int'(topLeftY), 195);

        // mixed collision vectors, plus launch while flying (ignored)
        foreach (vec[i]) drive(vec[i][6], vec[i][5], vec[i][4], vec[i][3:0], 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        frame(1'b0);

        // flipper at Yspeed = 220 -> -230
        resetN = 1'b1;
        idle();
        resetN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) frame(1'b0);
        chk("pre_flipper_Y", int'(topLeftY), 259);
        drive(1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        frame(1'b0);
        chk("flipper_clamp_Y", int'(topLeftY), 255);

        // fall until lost
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            drive(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
            if (m_mode == M_GONE) begin
                found = 1'b1;
                chk("lost_pulse", int'(ballLost), 1);
            end else begin
                idle();
                idle();
            end
        end
        if (!found) chk("lost_timeout", 0, 1);
        idle();
        chk("rearm_ballLost", int'(ballLost), 0);
        chk("rearm_running", int'(running), 0);
        chk("rearm_X", int'(topLeftX), 280);
        chk("rearm_Y", int'(topLeftY), 185);

        // reset mid-flight with launch held
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        frame(1'b0);
        frame(1'b0);
        frame(1'b0);
        resetN = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("midreset_running", int'(running), 0);
        chk("midreset_X", int'(topLeftX), 280);
        chk("midreset_Y", int'(topLeftY), 185);
        resetN = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("relaunch_running", int'(running), 1);
        frame(1'b0);
        chk("relaunch_Y", int'(topLeftY), 186);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
